// File: rtl/sync_debounce.sv
// Per-bit level debouncer: a bit of o changes only after STABLE_CYCLES consecutive mismatching samples.
// Define SYNC_DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch counter (glitch_clr_i / glitch_cnt_o).
module sync_debounce #(
  parameter int               WIDTH         = 1,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] i,
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  input  logic             glitch_clr_i,
  output logic [15:0]      glitch_cnt_o,
`endif
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_PENDING} state_e;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] abort;
  logic             first_q;

  // first_q blocks acceptance on the first edge after reset release so no pulse can appear there
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      o_d[b]     = o[b];
      rise_d[b]  = 1'b0;
      fall_d[b]  = 1'b0;
      abort[b]   = 1'b0;
      if (i[b] == o[b]) begin
        abort[b]   = (state_q[b] == ST_PENDING);
        state_d[b] = ST_STABLE;
        cnt_d[b]   = '0;
      end else if (cnt_q[b] < CNT_LAST) begin
        cnt_d[b]   = cnt_q[b] + 1'b1;
        state_d[b] = ST_PENDING;
      end else if (!first_q) begin
        o_d[b]     = i[b];
        rise_d[b]  = i[b];
        fall_d[b]  = ~i[b];
        cnt_d[b]   = '0;
        state_d[b] = ST_STABLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < WIDTH; b++) begin
        state_q[b] <= ST_STABLE;
        cnt_q[b]   <= '0;
      end
      o       <= RESET_VALUE;
      rise_o  <= '0;
      fall_o  <= '0;
      first_q <= 1'b1;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      o       <= o_d;
      rise_o  <= rise_d;
      fall_o  <= fall_d;
      first_q <= 1'b0;
    end
  end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      glitch_cnt_o <= '0;
    end else if (glitch_clr_i) begin
      glitch_cnt_o <= '0;
    end else if (|abort) begin
      glitch_cnt_o <= sat_inc16(glitch_cnt_o);
    end
  end
`else
  logic unused_abort;
  assign unused_abort = ^abort;
`endif

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent filtered bits, range 1..64.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4: consecutive mismatching samples needed to accept a new level, range 1..65535.
REQ-003 SHALL have parameter RESET_VALUE, WIDTH bits, default all-zero: reset level of the filtered output.
REQ-004 SHALL have port clk_i, input, 1: sole clock; one clock, all state in this domain.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port i, input, WIDTH: already-synchronized level input, the output of a two-or-more-rank synchronizer in the clk_i domain.
REQ-007 SHALL have port o, output, WIDTH: debounced level.
REQ-008 SHALL have port rise_o, output, WIDTH: one-cycle pulse per bit on an accepted 0->1 change of o.
REQ-009 SHALL have port fall_o, output, WIDTH: one-cycle pulse per bit on an accepted 1->0 change of o.
REQ-010 SHALL have port glitch_clr_i, input, 1: synchronous clear of the glitch counter (present only with the macro, see Configuration).
REQ-011 SHALL have port glitch_cnt_o, output, 16: saturating glitch count (present only with the macro).

Function
REQ-012 SHALL keep, per bit b, a counter cnt[b] of width $clog2(STABLE_CYCLES+1) and a two-state FSM: STABLE (i[b]==o[b]) and PENDING (i[b]!=o[b] seen, cnt[b]>0).
REQ-013 SHALL, at each clock edge where i[b]==o[b], set cnt[b] to 0 and the bit FSM to STABLE.
REQ-014 SHALL, at each edge where i[b]!=o[b] and cnt[b]<STABLE_CYCLES-1, increment cnt[b] and enter or stay in PENDING.
REQ-015 SHALL, at the edge where i[b]!=o[b] and cnt[b]==STABLE_CYCLES-1, load o[b]<=i[b], clear cnt[b] and return to STABLE, so o changes on the STABLE_CYCLES-th consecutive mismatching edge.
REQ-016 SHALL give STABLE_CYCLES=1 a plain one-register delay: o follows i one edge later, and no bit ever enters PENDING.
REQ-017 SHALL register rise_o[b] and fall_o[b] so they are high in exactly the cycle o[b] first shows its new value, for one cycle only.
REQ-018 SHALL treat a PENDING bit whose i[b] returns to o[b] before acceptance as a glitch: o[b] unchanged, no edge pulse.
REQ-019 SHALL process bits independently; simultaneous changes on several bits SHALL each complete on their own schedule.

Reset
REQ-020 SHALL, while rst_ni is low, asynchronously force o=RESET_VALUE, rise_o=0, fall_o=0, all cnt=0, all FSMs=STABLE and glitch_cnt_o=0.
REQ-021 SHALL discard any in-progress PENDING count when reset is asserted mid-operation; counting restarts from 0 after release.
REQ-022 SHALL produce no rise/fall pulse on the first edge after release, even if i differs from RESET_VALUE; normal filtering then applies.

Configuration
REQ-023 SHALL, when SYNC_DEBOUNCE_GLITCH_CNT_EN is defined, include glitch_clr_i, glitch_cnt_o and a 16-bit counter that increments by 1 on any edge where at least one bit aborts per REQ-018, holds at 0xFFFF, and clears to 0 on glitch_clr_i, with clear taking priority over a simultaneous increment.
REQ-024 SHALL, when SYNC_DEBOUNCE_GLITCH_CNT_EN is undefined, omit both ports and the counter, with all other behaviour identical.

Verification
REQ-025 SHALL cover step: STABLE_CYCLES=4, i 0->1 held -> o=1 and rise_o=1 for one cycle after the 4th edge seeing i=1; fall_o stays 0.
REQ-026 SHALL cover glitch: i high for 3 edges then low -> o stays 0, no pulses, glitch_cnt_o 0->1.
REQ-027 SHALL cover saturation: glitch_cnt_o forced near 0xFFFF by repeated 2-edge pulses -> holds at 0xFFFF; glitch_clr_i together with a glitch -> 0.
REQ-028 SHALL cover STABLE_CYCLES=1, WIDTH=8: i=0xA5 -> o=0xA5 one edge later, rise_o=0xA5, then i=0x00 -> fall_o=0xA5.
REQ-029 SHALL cover reset mid-PENDING: i=1 for 2 edges, assert rst_ni low -> o=RESET_VALUE immediately; after release i=1 needs 4 full edges before o=1.
REQ-030 SHALL cover independent bits: WIDTH=2, bit0 stable high from t0, bit1 high from t0+2 -> rise_o=01 then 10 two cycles apart.
